gcd_unit: RTL and testbench

- Self-contained, parametrised GCD engine using repeated subtraction (Euclid).
- Successor to the fixed 8-bit GCD datapath plus external controller: datapath, FSM and handshakes are merged into one block.
- Adds generic operand width, valid/ready handshakes on input and output, an iteration counter, a zero-operand fast path and a synchronous abort.
- Sits between the operand source (switch/UART front end) and the display/result consumer.

---
 rtl/gcd_unit_if.sv | 33 +++
 rtl/gcd_unit.sv | 119 +++++++++++
 tb/tb_gcd_unit.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gcd_unit_if.sv
// rtl/gcd_unit_if.sv - operand/result handshake bundle for gcd_unit
//
// Groups the operand input handshake, the result output handshake and the
// status/abort lines of gcd_unit.
//   master : operand source / result consumer side
//   slave  : gcd_unit side
// WIDTH and ITER_W must match the parameters of the attached gcd_unit.
interface gcd_unit_if #(
  parameter int WIDTH  = 8,
  parameter int ITER_W = WIDTH
);
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  x_i;
  logic [WIDTH-1:0]  y_i;
  logic              abort;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  d_o;
  logic [ITER_W-1:0] iter_cnt;
  logic              zero_flag;
  logic              busy;

  modport master (
    output in_valid, x_i, y_i, abort, out_ready,
    input  in_ready, out_valid, d_o, iter_cnt, zero_flag, busy
  );

  modport slave (
    input  in_valid, x_i, y_i, abort, out_ready,
    output in_ready, out_valid, d_o, iter_cnt, zero_flag, busy
  );
endinterface

// File: rtl/gcd_unit.sv
// rtl/gcd_unit.sv - subtractive Euclid GCD engine with valid/ready handshakes
//
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : gcd_unit_if.slave
//     in_valid/in_ready/x_i/y_i   operand pair handshake (ready only in IDLE)
//     out_valid/out_ready         result handshake (valid only in DONE)
//     d_o/iter_cnt/zero_flag      result, subtraction count, zero-operand flag
//     abort                       cancel an in-flight computation (CALC only)
//     busy                        computation in progress
module gcd_unit #(
  parameter int WIDTH  = 8,
  parameter int ITER_W = WIDTH
) (
  input  logic      clk,
  input  logic      reset,
  gcd_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_n;
  logic [WIDTH-1:0]  x_q, x_n;
  logic [WIDTH-1:0]  y_q, y_n;
  logic [WIDTH-1:0]  d_q, d_n;
  logic [ITER_W-1:0] iter_q, iter_n;
  logic              zero_q, zero_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      d_q     <= '0;
      iter_q  <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      x_q     <= x_n;
      y_q     <= y_n;
      d_q     <= d_n;
      iter_q  <= iter_n;
      zero_q  <= zero_n;
    end
  end

  always_comb begin
    state_n = state_q;
    x_n     = x_q;
    y_n     = y_q;
    d_n     = d_q;
    iter_n  = iter_q;
    zero_n  = zero_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          x_n    = bus.x_i;
          y_n    = bus.y_i;
          iter_n = '0;
          // A zero operand short-circuits: gcd(0,b)=b and gcd(0,0)=0,
          // both of which are just the OR of the operands.
          if (bus.x_i == '0 || bus.y_i == '0) begin
            d_n     = bus.x_i | bus.y_i;
            zero_n  = 1'b1;
            state_n = DONE;
          end else begin
            zero_n  = 1'b0;
            state_n = CALC;
          end
        end
      end

      CALC: begin
        // Abort wins over the step; d_o/zero_flag keep their old values and
        // iter_cnt keeps the partial count.
        if (bus.abort) begin
          state_n = IDLE;
        end else if (x_q == y_q) begin
          d_n     = x_q;
          state_n = DONE;
        end else begin
          // Only the larger operand is reduced, so no underflow is possible.
          if (x_q < y_q) begin
            y_n = y_q - x_q;
          end else begin
            x_n = x_q - y_q;
          end
          if (iter_q != '1) begin
            iter_n = iter_q + ITER_W'(1);
          end
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          state_n = IDLE;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q == CALC);
  assign bus.out_valid = (state_q == DONE);
  assign bus.d_o       = d_q;
  assign bus.iter_cnt  = iter_q;
  assign bus.zero_flag = zero_q;

endmodule

// File: tb/tb_gcd_unit.sv
// tb/tb_gcd_unit.sv - self-checking bench for gcd_unit
module tb_gcd_unit;

  localparam int W  = 16;
  localparam int IW = 16;
  localparam int LIMIT = 3000;

  logic clk;
  logic reset;

  int n_checks;
  int n_fail;

  // values the main DUT should still be showing after an abort
  int unsigned last_d;
  int unsigned last_zero;

  gcd_unit_if #(.WIDTH(W), .ITER_W(IW)) g ();
  gcd_unit_if #(.WIDTH(8), .ITER_W(4))  s ();

  gcd_unit #(.WIDTH(W), .ITER_W(IW)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (g)
  );

  gcd_unit #(.WIDTH(8), .ITER_W(4)) u_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: classic Euclid with division. Subtraction count equals the sum
  // of the quotients minus one (the final equal step does not subtract).
  function automatic void ref_gcd(input int unsigned a, input int unsigned b,
                                  output int unsigned gg, output int unsigned k);
    int unsigned p, q, t, cnt;
    if (a == 0 || b == 0) begin
      gg = a | b;
      k  = 0;
      return;
    end
    p = (a > b) ? a : b;
    q = (a > b) ? b : a;
    cnt = 0;
    while (q != 0) begin
      cnt += p / q;
      t = p % q;
      p = q;
      q = t;
    end
    gg = p;
    k  = cnt - 1;
  endfunction

  // One operation on the main DUT: accept, time the result, hold it for
  // `hold` cycles with out_ready low, then hand it off.
  task automatic run_op(input int unsigned x, input int unsigned y,
                        input int hold, input bit poke, input string name);
    int unsigned exp_d, k, exp_lat;
    int lat, busy_n;
    ref_gcd(x, y, exp_d, k);
    exp_lat = (x == 0 || y == 0) ? 0 : k + 1;

    @(negedge clk);
    n_checks++;
    if (g.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s idle_ready: got %b want 1", name, g.in_ready);
    end
    g.x_i = W'(x);
    g.y_i = W'(y);
    g.in_valid = 1'b1;
    g.out_ready = 1'b0;
    @(negedge clk);
    g.in_valid = 1'b0;

    lat = 0;
    busy_n = 0;
    while (g.out_valid !== 1'b1 && lat < LIMIT) begin
      if (g.busy === 1'b1) busy_n++;
      if (poke) begin
        g.in_valid = 1'b1;
        g.x_i = W'(7);
        g.y_i = W'(5);
      end
      @(negedge clk);
      lat++;
    end

    n_checks++;
    if (lat != int'(exp_lat)) begin
      n_fail++;
      $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
    end
    n_checks++;
    if (busy_n != int'(exp_lat)) begin
      n_fail++;
      $display("FAIL %s busy_cycles: got %0d want %0d", name, busy_n, exp_lat);
    end
    n_checks++;
    if (g.d_o !== W'(exp_d)) begin
      n_fail++;
      $display("FAIL %s d_o: got %0d want %0d", name, g.d_o, exp_d);
    end
    n_checks++;
    if (g.iter_cnt !== IW'(k)) begin
      n_fail++;
      $display("FAIL %s iter_cnt: got %0d want %0d", name, g.iter_cnt, k);
    end
    n_checks++;
    if (g.zero_flag !== ((x == 0 || y == 0) ? 1'b1 : 1'b0)) begin
      n_fail++;
      $display("FAIL %s zero_flag: got %b", name, g.zero_flag);
    end

    for (int i = 0; i < hold; i++) begin
      if (poke) begin
        g.in_valid = 1'b1;
        g.x_i = W'(7);
        g.y_i = W'(5);
      end
      @(negedge clk);
      n_checks++;
      if (g.out_valid !== 1'b1 || g.d_o !== W'(exp_d) || g.iter_cnt !== IW'(k)) begin
        n_fail++;
        $display("FAIL %s hold%0d: got v=%b d=%0d it=%0d want v=1 d=%0d it=%0d",
                 name, i, g.out_valid, g.d_o, g.iter_cnt, exp_d, k);
      end
    end

    g.in_valid = 1'b0;
    g.out_ready = 1'b1;
    @(negedge clk);
    g.out_ready = 1'b0;
    n_checks++;
    if (g.in_ready !== 1'b1 || g.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s handoff: got in_ready=%b out_valid=%b want 1/0",
               name, g.in_ready, g.out_valid);
    end
    last_d = exp_d;
    last_zero = (x == 0 || y == 0) ? 1 : 0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (g.in_ready !== 1'b1 || g.out_valid !== 1'b0 || g.busy !== 1'b0 ||
        g.d_o !== '0 || g.iter_cnt !== '0 || g.zero_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got rdy=%b ov=%b busy=%b d=%0d it=%0d z=%b",
               g.in_ready, g.out_valid, g.busy, g.d_o, g.iter_cnt, g.zero_flag);
    end
    last_d = 0;
    last_zero = 0;
  endtask

  task automatic test_basic();
    run_op(12, 18, 0, 1'b0, "basic_12_18");
  endtask

  task automatic test_long_and_zero();
    run_op(255, 1, 0, 1'b0, "long_255_1");
    run_op(0, 35, 0, 1'b0, "zero_0_35");
    run_op(0, 0, 0, 1'b0, "zero_0_0");
    run_op(35, 0, 1, 1'b0, "zero_35_0");
  endtask

  task automatic test_hold();
    run_op(1071, 462, 5, 1'b1, "hold_1071_462");
    run_op(40, 40, 2, 1'b0, "equal_40");
  endtask

  task automatic test_abort();
    // abort while idle must do nothing
    @(negedge clk);
    g.abort = 1'b1;
    @(negedge clk);
    g.abort = 1'b0;
    n_checks++;
    if (g.in_ready !== 1'b1 || g.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle: got in_ready=%b busy=%b want 1/0", g.in_ready, g.busy);
    end

    g.x_i = W'(200);
    g.y_i = W'(3);
    g.in_valid = 1'b1;
    @(negedge clk);
    g.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    g.abort = 1'b1;
    @(negedge clk);
    g.abort = 1'b0;
    n_checks++;
    if (g.in_ready !== 1'b1 || g.busy !== 1'b0 || g.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_state: got rdy=%b busy=%b ov=%b want 1/0/0",
               g.in_ready, g.busy, g.out_valid);
    end
    n_checks++;
    if (g.iter_cnt !== IW'(3) || g.d_o !== W'(last_d) || g.zero_flag !== last_zero[0]) begin
      n_fail++;
      $display("FAIL abort_regs: got it=%0d d=%0d z=%b want it=3 d=%0d z=%0d",
               g.iter_cnt, g.d_o, g.zero_flag, last_d, last_zero);
    end
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        if (g.out_valid === 1'b1) seen = 1'b1;
      end
      n_checks++;
      if (seen) begin
        n_fail++;
        $display("FAIL abort_no_result: got out_valid=1 want 0");
      end
    end
    run_op(9, 6, 0, 1'b0, "after_abort_9_6");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    g.x_i = W'(100);
    g.y_i = W'(75);
    g.in_valid = 1'b1;
    @(negedge clk);
    g.in_valid = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (g.in_ready !== 1'b1 || g.out_valid !== 1'b0 || g.busy !== 1'b0 ||
        g.d_o !== '0 || g.iter_cnt !== '0 || g.zero_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: got rdy=%b ov=%b busy=%b d=%0d it=%0d z=%b",
               g.in_ready, g.out_valid, g.busy, g.d_o, g.iter_cnt, g.zero_flag);
    end
    @(negedge clk);
    reset = 1'b1;
    last_d = 0;
    last_zero = 0;
    run_op(8, 12, 0, 1'b0, "after_reset_8_12");
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++) begin
      int unsigned a, b;
      a = (i % 7 == 3) ? 0 : $urandom_range(1, 600);
      b = $urandom_range(1, 600);
      run_op(a, b, $urandom_range(0, 3), 1'b0, $sformatf("rand%0d", i));
    end
  endtask

  task automatic test_saturation();
    int unsigned pa[2];
    int unsigned pb[2];
    pa[0] = 255; pb[0] = 1;
    pa[1] = 40;  pb[1] = 24;
    for (int i = 0; i < 2; i++) begin
      int unsigned exp_d, k, exp_it;
      int lat;
      ref_gcd(pa[i], pb[i], exp_d, k);
      exp_it = (k > 15) ? 15 : k;
      @(negedge clk);
      s.x_i = 8'(pa[i]);
      s.y_i = 8'(pb[i]);
      s.in_valid = 1'b1;
      @(negedge clk);
      s.in_valid = 1'b0;
      lat = 0;
      while (s.out_valid !== 1'b1 && lat < LIMIT) begin
        @(negedge clk);
        lat++;
      end
      n_checks++;
      if (s.out_valid !== 1'b1 || s.d_o !== 8'(exp_d)) begin
        n_fail++;
        $display("FAIL sat%0d d_o: got v=%b d=%0d want v=1 d=%0d", i, s.out_valid, s.d_o, exp_d);
      end
      n_checks++;
      if (s.iter_cnt !== 4'(exp_it)) begin
        n_fail++;
        $display("FAIL sat%0d iter_cnt: got %0d want %0d", i, s.iter_cnt, exp_it);
      end
      s.out_ready = 1'b1;
      @(negedge clk);
      s.out_ready = 1'b0;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    reset = 1'b0;
    g.in_valid = 1'b0; g.x_i = '0; g.y_i = '0; g.abort = 1'b0; g.out_ready = 1'b0;
    s.in_valid = 1'b0; s.x_i = '0; s.y_i = '0; s.abort = 1'b0; s.out_ready = 1'b0;

    test_reset();
    test_basic();
    test_long_and_zero();
    test_hold();
    test_abort();
    test_reset_mid();
    test_random();
    test_saturation();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
